// File: rtl/rv32i_types.sv
// Shared types for the memory-port arbiter: grant FSM states and the latched request.
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_enable;
    logic        write;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_RST = '{addr: 32'h0, wdata: 32'h0, byte_enable: 4'h0, write: 1'b0};

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between instruction fetch and data access,
// latching the winning request for the whole transfer and stalling the pipeline meanwhile.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_enable,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        stall
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  mem_req_t            req_q, req_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                d_req;
  logic                at_limit;

  always_comb begin
    d_req       = d_read | d_write;
    at_limit    = (streak_q == STREAK_MAX);
    state_d     = state_q;
    streak_d    = streak_q;
    req_d       = req_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    unique case (state_q)
      ARB_IDLE: begin
        // Data wins ties unless it has already starved a waiting fetch for MAX_D_STREAK grants.
        if (d_req && !(i_read && at_limit)) begin
          state_d     = ARB_SERVE_D;
          req_d       = '{addr: d_addr, wdata: d_wdata, byte_enable: d_byte_enable,
                          write: d_write & ~d_read};
          mem_read_d  = d_read;
          mem_write_d = d_write & ~d_read;
          streak_d    = i_read ? (at_limit ? streak_q : streak_q + 1'b1) : '0;
        end else if (i_read) begin
          state_d     = ARB_SERVE_I;
          req_d       = '{addr: i_addr, wdata: 32'h0, byte_enable: 4'hF, write: 1'b0};
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          streak_d    = '0;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (mem_resp) begin
          state_d     = ARB_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      streak_q    <= '0;
      req_q       <= MEM_REQ_RST;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      req_q       <= req_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_addr        = req_q.addr;
  assign mem_wdata       = req_q.wdata;
  assign mem_byte_enable = req_q.byte_enable;

  // Responses only count while serving; a stray mem_resp in idle is dropped.
  assign i_resp  = (state_q == ARB_SERVE_I) & mem_resp;
  assign d_resp  = (state_q == ARB_SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign stall   = (i_read & ~i_resp) | (d_req & ~d_resp);

endmodule
